// File: rtl/led_scanner_pkg.sv
// Shared types for the LED pattern scanner.
// Mode and direction encodings used by all scanner files.
package led_scanner_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE,
    MODE_ROT_L,
    MODE_ROT_R,
    MODE_COUNT
  } mode_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/led_scanner_rise.sv
// Rising-edge detector for slow synchronous level inputs.
// The history flop resets to RST_VAL so a held input gives no pulse.
module rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/led_scanner.sv
// LED pattern generator: bounce, rotate left/right and binary count.
// One pattern step per rising edge of the divider square wave.
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         pause,
  input  logic [1:0]   mode,
  output logic [W-1:0] leds,
  output logic         dir,
  output logic         step,
  output logic         wrap
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;
  localparam logic [PW-1:0] PMAX = PW'(W - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [W-1:0] ONE = W'(1);

  logic          edge_raw;
  mode_t         mode_q;
  logic          chg_p;
  logic          acc_p;
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_n;
  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_n;
  dir_t          dir_q;
  dir_t          dir_n;
  logic          wrap_n;
  logic [W-1:0]  leds_n;

  rise_detect #(
    .RST_VAL(1'b1)
  ) u_rise (
    .clk  (clk),
    .reset(reset),
    .d    (tick),
    .rise (edge_raw)
  );

  // A mode change outranks an edge arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_BOUNCE;
      chg_p  <= 1'b0;
      acc_p  <= 1'b0;
    end else begin
      mode_q <= mode_t'(mode);
      chg_p  <= (mode != mode_q);
      acc_p  <= edge_raw & ~pause
              & (mode == mode_q);
    end
  end

  always_comb begin
    pos_n  = pos;
    cnt_n  = cnt;
    dir_n  = dir_q;
    wrap_n = 1'b0;
    unique case (mode_q)
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          if (pos == PMAX) begin
            pos_n  = PMAX - PONE;
            dir_n  = DIR_DOWN;
            wrap_n = 1'b1;
          end else begin
            pos_n = pos + PONE;
          end
        end else begin
          if (pos == '0) begin
            pos_n  = PONE;
            dir_n  = DIR_UP;
            wrap_n = 1'b1;
          end else begin
            pos_n = pos - PONE;
          end
        end
      end
      MODE_ROT_L: begin
        if (pos == PMAX) begin
          pos_n  = '0;
          wrap_n = 1'b1;
        end else begin
          pos_n = pos + PONE;
        end
      end
      MODE_ROT_R: begin
        if (pos == '0) begin
          pos_n  = PMAX;
          wrap_n = 1'b1;
        end else begin
          pos_n = pos - PONE;
        end
      end
      MODE_COUNT: begin
        cnt_n  = cnt + ONE;
        wrap_n = (cnt == '1);
      end
      default: ;
    endcase
  end

  assign leds_n = (mode_q == MODE_COUNT)
                ? cnt_n : (ONE << pos_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      pos   <= '0;
      cnt   <= '0;
      dir_q <= DIR_UP;
      leds  <= ONE;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (chg_p) begin
      pos   <= '0;
      cnt   <= '0;
      dir_q <= DIR_UP;
      leds  <= (mode_q == MODE_COUNT)
             ? '0 : ONE;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (acc_p) begin
      pos   <= pos_n;
      cnt   <= cnt_n;
      dir_q <= dir_n;
      leds  <= leds_n;
      step  <= 1'b1;
      wrap  <= wrap_n;
    end else begin
      step  <= 1'b0;
      wrap  <= 1'b0;
    end
  end

  assign dir = (dir_q == DIR_DOWN);

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner at W = 8, 5 and 4.
// All three instances share stimulus; each test watches one.
module tb_led_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       pause;
  logic [1:0] mode;

  logic [7:0] leds8;
  logic       dir8, step8, wrap8;
  logic [4:0] leds5;
  logic       dir5, step5, wrap5;
  logic [3:0] leds4;
  logic       dir4, step4, wrap4;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  led_scanner #(.W(8)) u8 (
    .clk(clk), .reset(reset), .tick(tick),
    .pause(pause), .mode(mode), .leds(leds8),
    .dir(dir8), .step(step8), .wrap(wrap8)
  );

  led_scanner #(.W(5)) u5 (
    .clk(clk), .reset(reset), .tick(tick),
    .pause(pause), .mode(mode), .leds(leds5),
    .dir(dir5), .step(step5), .wrap(wrap5)
  );

  led_scanner #(.W(4)) u4 (
    .clk(clk), .reset(reset), .tick(tick),
    .pause(pause), .mode(mode), .leds(leds4),
    .dir(dir4), .step(step4), .wrap(wrap4)
  );

  // Tick high for one cycle; returns #1 after the update edge.
  task automatic do_edge();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk); mode = m;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b1;
    pause = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (step8 !== 1'b0)
        $display("FAIL rst_step c%0d got %b exp 0",
                 i, step8);
      else pass_cnt++;
    end
    total++;
    if (leds8 !== 8'h01)
      $display("FAIL rst_leds8 got %h exp 01", leds8);
    else pass_cnt++;
    total++;
    if ({dir8, wrap8} !== 2'b00)
      $display("FAIL rst_dirwrap got %b exp 00",
               {dir8, wrap8});
    else pass_cnt++;
    total++;
    if ({leds5, leds4} !== {5'h01, 4'h1})
      $display("FAIL rst_leds54 got %h %h exp 01 1",
               leds5, leds4);
    else pass_cnt++;
    @(negedge clk); tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] b_leds [16] = '{
    8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h40,
    8'h20, 8'h10, 8'h08, 8'h04,
    8'h02, 8'h01, 8'h02, 8'h04
  };

  task automatic test_bounce();
    logic ew, ed;
    for (int i = 1; i <= 16; i++) begin
      do_edge();
      ew = (i == 8) || (i == 15);
      ed = (i >= 8) && (i <= 14);
      total++;
      if ({leds8, dir8, wrap8, step8} !==
          {b_leds[i-1], ed, ew, 1'b1})
        $display("FAIL bounce e%0d got %h/%b%b%b exp %h/%b%b1",
                 i, leds8, dir8, wrap8, step8,
                 b_leds[i-1], ed, ew);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    total++;
    if ({step8, wrap8} !== 2'b00)
      $display("FAIL step_pulse got %b exp 00",
               {step8, wrap8});
    else pass_cnt++;
  endtask

  logic [4:0] rl_leds [5] = '{
    5'h02, 5'h04, 5'h08, 5'h10, 5'h01
  };

  task automatic test_rotate();
    set_mode(2'd1);
    total++;
    if (leds5 !== 5'h01)
      $display("FAIL rotl_reload got %h exp 01", leds5);
    else pass_cnt++;
    for (int i = 1; i <= 5; i++) begin
      do_edge();
      total++;
      if ({leds5, wrap5, dir5} !==
          {rl_leds[i-1], (i == 5), 1'b0})
        $display("FAIL rotl e%0d got %h/%b%b exp %h/%b0",
                 i, leds5, wrap5, dir5,
                 rl_leds[i-1], (i == 5));
      else pass_cnt++;
    end
    set_mode(2'd2);
    total++;
    if (leds5 !== 5'h01)
      $display("FAIL rotr_reload got %h exp 01", leds5);
    else pass_cnt++;
    do_edge();
    total++;
    if ({leds5, wrap5, step5} !== {5'h10, 2'b11})
      $display("FAIL rotr_e1 got %h/%b%b exp 10/11",
               leds5, wrap5, step5);
    else pass_cnt++;
    do_edge();
    total++;
    if ({leds5, wrap5} !== {5'h08, 1'b0})
      $display("FAIL rotr_e2 got %h/%b exp 08/0",
               leds5, wrap5);
    else pass_cnt++;
  endtask

  task automatic test_count();
    logic [3:0] e;
    set_mode(2'd3);
    total++;
    if (leds4 !== 4'h0)
      $display("FAIL cnt_reload got %h exp 0", leds4);
    else pass_cnt++;
    for (int i = 1; i <= 16; i++) begin
      do_edge();
      e = 4'(i);
      total++;
      if ({leds4, wrap4, dir4} !== {e, (i == 16), 1'b0})
        $display("FAIL cnt e%0d got %h/%b%b exp %h/%b0",
                 i, leds4, wrap4, dir4, e, (i == 16));
      else pass_cnt++;
    end
  endtask

  task automatic test_pause_modechg();
    @(negedge clk); pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_edge();
      total++;
      if ({leds4, step4} !== {4'h0, 1'b0})
        $display("FAIL pause e%0d got %h/%b exp 0/0",
                 i, leds4, step4);
      else pass_cnt++;
    end
    @(negedge clk); pause = 1'b0;
    do_edge();
    total++;
    if ({leds4, step4} !== {4'h1, 1'b1})
      $display("FAIL unpause got %h/%b exp 1/1",
               leds4, step4);
    else pass_cnt++;
    @(negedge clk); tick = 1'b1; mode = 2'd0;
    @(negedge clk); tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({leds4, step4, wrap4} !== {4'h1, 2'b00})
        $display("FAIL mchg c%0d got %h/%b%b exp 1/00",
                 i, leds4, step4, wrap4);
      else pass_cnt++;
    end
    do_edge();
    total++;
    if ({leds4, step4} !== {4'h2, 1'b1})
      $display("FAIL mchg_next got %h/%b exp 2/1",
               leds4, step4);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 9; i++) do_edge();
    total++;
    if ({leds8, dir8} !== {8'h20, 1'b1})
      $display("FAIL mid_pre got %h/%b exp 20/1",
               leds8, dir8);
    else pass_cnt++;
    @(negedge clk); reset = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({leds8, dir8, step8} !== {8'h01, 2'b00})
      $display("FAIL mid_rst got %h/%b%b exp 01/00",
               leds8, dir8, step8);
    else pass_cnt++;
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({leds8, step8} !== {8'h01, 1'b0})
      $display("FAIL mid_hold got %h/%b exp 01/0",
               leds8, step8);
    else pass_cnt++;
    @(negedge clk); tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_rotate();
    test_count();
    test_pause_modechg();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
